sample_dma_req_arbiter: RTL and testbench

Round-robin arbiter that shares the AXI bridge DMA read-request port between `NUM_REQ` independent requesters, e.g. the sample DMA requester and a future instrument-header fetcher. It sits between the requesters and the AXI bridge. It latches single-cycle request pulses, grants one requester at a time, and forwards that requester's address, ID and length to the bridge. It routes the bridge's completion pulse back to the granted requester and holds the grant until that completion arrives.

---
 rtl/sample_dma_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_sample_dma_req_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dma_req_arbiter.sv
// Round-robin arbiter sharing the bridge DMA read-request port.
// Latches request pulses, issues one grant at a time, waits for completion.
module sample_dma_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 6,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*ID_W-1:0]    req_id,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [ADDR_W-1:0]          dma_req_addr,
    output logic [ID_W-1:0]            dma_req_id,
    output logic [LEN_W-1:0]           dma_req_len,
    output logic                       dma_req_valid,
    input  logic                       dma_req_done,
    input  logic                       stop,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       protocol_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;

    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    int                 pos;
    logic [NUM_REQ-1:0] grant_clr;
    logic [NUM_REQ-1:0] owned;
    logic [NUM_REQ-1:0] accept;

    // Round-robin pick: first pending bit after the last grant, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        pos     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = IDX_W'(pos);
            if (!sel_vld && pending_q[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Grant FSM next state, captured request fields and completion pulse.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        done_d    = '0;
        grant_clr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!stop && sel_vld) begin
                    grant_d   = sel_idx;
                    last_d    = sel_idx;
                    addr_d    = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
                    id_d      = req_id[int'(sel_idx)*ID_W +: ID_W];
                    len_d     = req_len[int'(sel_idx)*LEN_W +: LEN_W];
                    grant_clr = NUM_REQ'(1) << sel_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dma_req_done) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending latch and sticky protocol error; illegal pulses are dropped.
    always_comb begin
        owned     = '0;
        if (state_q != S_IDLE) owned = NUM_REQ'(1) << grant_q;
        accept    = req_valid & ~pending_q & ~owned;
        pending_d = stop ? '0 : ((pending_q & ~grant_clr) | accept);
        err_d     = err_q
                  | (|(req_valid & pending_q))
                  | (|(req_valid & owned))
                  | (dma_req_done && (state_q != S_WAIT));
    end

    // State registers; last grant starts at the top so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_done      = done_q;
    assign dma_req_addr  = addr_q;
    assign dma_req_id    = id_q;
    assign dma_req_len   = len_q;
    assign dma_req_valid = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign grant_idx     = grant_q;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_sample_dma_req_arbiter.sv
// Scoreboard bench for sample_dma_req_arbiter.
// A transaction-level model predicts bridge requests and completions.
module tb_sample_dma_req_arbiter;

    localparam int N = 2;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] a;
        logic [5:0]  id;
        logic [7:0]  len;
    } req_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] v;
    } done_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*32-1:0] req_addr;
    logic [N*6-1:0]  req_id;
    logic [N*8-1:0]  req_len;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_done;
    logic [31:0]     dma_req_addr;
    logic [5:0]      dma_req_id;
    logic [7:0]      dma_req_len;
    logic            dma_req_valid;
    logic            dma_req_done = 1'b0;
    logic            stop = 1'b0;
    logic            busy;
    logic [0:0]      grant_idx;
    logic            protocol_err;

    bit          rv[N];
    logic [31:0] d_addr[N];
    logic [5:0]  d_id[N];
    logic [7:0]  d_len[N];

    // Reference model state
    bit   m_pend[N];
    int   m_last;
    int   m_grant;
    int   m_out;
    bit   m_issuing;
    bit   m_err;
    int   cyc = 0;

    req_t  exp_req[$];
    done_t exp_done[$];
    req_t  obs_req[$];
    done_t obs_done[$];

    int n_checks = 0;
    int n_fail = 0;

    sample_dma_req_arbiter #(
        .NUM_REQ(N), .ADDR_W(32), .ID_W(6), .LEN_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_id(req_id), .req_len(req_len),
        .req_valid(req_valid), .req_done(req_done),
        .dma_req_addr(dma_req_addr), .dma_req_id(dma_req_id),
        .dma_req_len(dma_req_len), .dma_req_valid(dma_req_valid),
        .dma_req_done(dma_req_done), .stop(stop), .busy(busy),
        .grant_idx(grant_idx), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_id    = '0;
        req_len   = '0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*32 +: 32] = d_addr[i];
            req_id[i*6 +: 6]     = d_id[i];
            req_len[i*8 +: 8]    = d_len[i];
            req_valid[i]         = rv[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_last    = N - 1;
        m_grant   = 0;
        m_out     = -1;
        m_issuing = 1'b0;
        m_err     = 1'b0;
        exp_req.delete();
        exp_done.delete();
        obs_req.delete();
        obs_done.delete();
    endtask

    // One clock edge of the arbiter rules, applied to the inputs held now.
    task automatic model_step();
        bit   idle, issuing, waiting;
        bit   np[N];
        int   g, c, pre_out;
        req_t  r;
        done_t d;
        idle    = (m_out < 0);
        issuing = (m_out >= 0) && m_issuing;
        waiting = (m_out >= 0) && !m_issuing;
        pre_out = m_out;
        for (int i = 0; i < N; i++) begin
            if (rv[i] && (m_pend[i] || pre_out == i)) m_err = 1'b1;
            np[i] = m_pend[i];
        end
        if (dma_req_done && !waiting) m_err = 1'b1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (g < 0 && m_pend[c]) g = c;
        end
        if (idle && !stop && g >= 0) begin
            np[g]     = 1'b0;
            m_last    = g;
            m_grant   = g;
            m_out     = g;
            m_issuing = 1'b1;
            r = '{cyc, g, d_addr[g], d_id[g], d_len[g]};
            exp_req.push_back(r);
        end else if (issuing) begin
            m_issuing = 1'b0;
        end else if (waiting && dma_req_done) begin
            d.cyc = cyc;
            d.v   = '0;
            d.v[m_out] = 1'b1;
            exp_done.push_back(d);
            m_out = -1;
        end
        for (int i = 0; i < N; i++)
            if (rv[i] && !m_pend[i] && pre_out != i) np[i] = 1'b1;
        for (int i = 0; i < N; i++) m_pend[i] = stop ? 1'b0 : np[i];
    endtask

    task automatic step_edge();
        @(posedge clk);
        cyc++;
        if (!reset) model_step();
        #1;
    endtask

    function automatic bit m_waiting();
        return (m_out >= 0) && !m_issuing;
    endfunction

    task automatic clr_in();
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        stop = 1'b0;
        dma_req_done = 1'b0;
    endtask

    task automatic pulse(input int i);
        d_addr[i] = $urandom;
        d_id[i]   = 6'($urandom);
        d_len[i]  = 8'($urandom);
        rv[i]     = 1'b1;
    endtask

    task automatic run(input int n, input bit auto_done);
        for (int k = 0; k < n; k++) begin
            clr_in();
            if (auto_done && m_waiting()) dma_req_done = 1'b1;
            step_edge();
        end
        clr_in();
    endtask

    task automatic run_to_wait(input int budget);
        int n;
        n = 0;
        while (!m_waiting() && n < budget) begin
            clr_in();
            step_edge();
            n++;
        end
        chk("wait_bound", 64'(m_waiting()), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(dma_req_valid), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gidx", 64'(grant_idx), 64'd0);
        chk("rst_err", 64'(protocol_err), 64'd0);
        chk("rst_addr", 64'(dma_req_addr), 64'd0);
        chk("rst_id", 64'(dma_req_id), 64'd0);
        chk("rst_len", 64'(dma_req_len), 64'd0);
        model_reset();
        clr_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every visible cycle against the expectation queues.
    always @(negedge clk) begin
        bit    ev;
        req_t  r;
        done_t d;
        logic [N-1:0] ed;
        if (!reset) begin
            ev = (exp_req.size() > 0) && (exp_req[0].cyc == cyc);
            chk("dma_valid", 64'(dma_req_valid), 64'(ev));
            if (dma_req_valid) begin
                r = '{cyc, int'(grant_idx), dma_req_addr, dma_req_id,
                      dma_req_len};
                obs_req.push_back(r);
            end
            if (ev) begin
                r = exp_req.pop_front();
                if (dma_req_valid) begin
                    chk("dma_idx", 64'(grant_idx), 64'(r.idx));
                    chk("dma_addr", 64'(dma_req_addr), 64'(r.a));
                    chk("dma_id", 64'(dma_req_id), 64'(r.id));
                    chk("dma_len", 64'(dma_req_len), 64'(r.len));
                end
            end
            ed = '0;
            if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
                d  = exp_done.pop_front();
                ed = d.v;
            end
            chk("req_done", 64'(req_done), 64'(ed));
            if (req_done != '0) begin
                d.cyc = cyc;
                d.v   = req_done;
                obs_done.push_back(d);
            end
            chk("busy", 64'(busy), 64'(m_out >= 0));
            chk("grant_idx", 64'(grant_idx), 64'(m_grant));
            chk("perr", 64'(protocol_err), 64'(m_err));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0;
            d_addr[i] = '0;
            d_id[i] = '0;
            d_len[i] = '0;
        end
        model_reset();
        do_reset();

        // Random legal traffic with occasional flushes.
        for (int k = 0; k < 2000; k++) begin
            clr_in();
            for (int i = 0; i < N; i++)
                if (!m_pend[i] && m_out != i && $urandom_range(0, 3) == 0)
                    pulse(i);
            if (m_waiting() && $urandom_range(0, 2) == 0)
                dma_req_done = 1'b1;
            if ($urandom_range(0, 49) == 0) stop = 1'b1;
            step_edge();
        end
        run(10, 1'b1);

        // Single request from requester 1, done four cycles after issue.
        do_reset();
        clr_in();
        d_addr[1] = 32'h1000_0040;
        d_id[1]   = 6'd5;
        d_len[1]  = 8'd64;
        rv[1]     = 1'b1;
        t = cyc;
        step_edge();
        clr_in();
        while (cyc < t + 6) step_edge();
        dma_req_done = 1'b1;
        step_edge();
        run(4, 1'b0);
        chk("single_n", 64'(obs_req.size()), 64'd1);
        if (obs_req.size() == 1) begin
            chk("single_cyc", 64'(obs_req[0].cyc), 64'(t + 2));
            chk("single_addr", 64'(obs_req[0].a), 64'h1000_0040);
            chk("single_id", 64'(obs_req[0].id), 64'd5);
            chk("single_len", 64'(obs_req[0].len), 64'd64);
        end
        chk("single_dn", 64'(obs_done.size()), 64'd1);
        if (obs_done.size() == 1) begin
            chk("single_dv", 64'(obs_done[0].v), 64'b10);
            chk("single_dc", 64'(obs_done[0].cyc), 64'(t + 7));
        end

        // Simultaneous requests out of reset.
        do_reset();
        clr_in();
        pulse(0);
        pulse(1);
        step_edge();
        run(12, 1'b1);
        chk("simul_n", 64'(obs_req.size()), 64'd2);
        if (obs_req.size() == 2) begin
            chk("simul_g0", 64'(obs_req[0].idx), 64'd0);
            chk("simul_g1", 64'(obs_req[1].idx), 64'd1);
        end

        // Fairness: both re-request as soon as they are free.
        obs_req.delete();
        for (int k = 0; k < 40; k++) begin
            clr_in();
            for (int i = 0; i < N; i++)
                if (!m_pend[i] && m_out != i) pulse(i);
            if (m_waiting()) dma_req_done = 1'b1;
            step_edge();
        end
        run(10, 1'b1);
        chk("fair_min", 64'(obs_req.size() >= 6), 64'd1);
        for (int k = 0; k < obs_req.size(); k++)
            chk("fair_alt", 64'(obs_req[k].idx), 64'(k % 2));

        // Stop flush while requester 0 is outstanding.
        do_reset();
        clr_in();
        pulse(0);
        pulse(1);
        step_edge();
        run_to_wait(10);
        stop = 1'b1;
        step_edge();
        run(8, 1'b1);
        chk("stop_n", 64'(obs_req.size()), 64'd1);
        if (obs_req.size() == 1)
            chk("stop_g", 64'(obs_req[0].idx), 64'd0);
        chk("stop_dn", 64'(obs_done.size()), 64'd1);
        if (obs_done.size() == 1)
            chk("stop_dv", 64'(obs_done[0].v), 64'b01);
        chk("stop_busy", 64'(busy), 64'd0);

        // Protocol errors: duplicate pulse, then done while idle.
        do_reset();
        clr_in();
        pulse(0);
        step_edge();
        clr_in();
        rv[0] = 1'b1;
        step_edge();
        run(8, 1'b1);
        chk("perr_dup", 64'(protocol_err), 64'd1);
        dma_req_done = 1'b1;
        step_edge();
        run(5, 1'b0);
        chk("perr_sticky", 64'(protocol_err), 64'd1);
        chk("perr_reqs", 64'(obs_req.size()), 64'd1);
        chk("perr_dones", 64'(obs_done.size()), 64'd1);

        // Reset during WAIT_DONE, then requester 0 wins first.
        do_reset();
        clr_in();
        pulse(1);
        step_edge();
        run_to_wait(10);
        run(1, 1'b0);
        do_reset();
        clr_in();
        pulse(0);
        pulse(1);
        step_edge();
        run(12, 1'b1);
        chk("rst_n", 64'(obs_req.size()), 64'd2);
        if (obs_req.size() > 0)
            chk("rst_first", 64'(obs_req[0].idx), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
